me_sequencer: RTL

Control and best-match unit for the motion-estimator processing-element array. It drives the reference and search memory addresses and the per-PE `S1S2mux`/`NewDist` controls. It also collects each PE's `Accumulate` result at the exact cycle it holds a complete sum of absolute differences, and reports the minimum-distortion candidate and its motion vector. It sits between the R/S memories and a systolic array of N PEs whose `R` inputs are chained through `Rpipe`. S1/S2 are broadcast to all PEs.

---
 rtl/me_seq_if.sv | 31 +++
 rtl/me_sequencer.sv | 135 +++++++++++++
 2 files changed

// File: rtl/me_seq_if.sv
// me_seq_if: sequencer <-> memory / PE-array signal bundle.
// master = sequencer side, slave = array / memory side.
interface me_seq_if #(
    parameter int N    = 16,
    parameter int LOGN = $clog2(N)
);
    logic              start;
    logic              busy;
    logic              done;
    logic [2*LOGN-1:0] AddressR;
    logic [2*LOGN+1:0] AddressS1;
    logic [2*LOGN+1:0] AddressS2;
    logic [N-1:0]      S1S2mux;
    logic [N-1:0]      NewDist;
    logic [8*N-1:0]    Accumulate;
    logic [7:0]        BestDist;
    logic [LOGN-1:0]   MotionX;
    logic [LOGN-1:0]   MotionY;

    modport master (
        input  start, Accumulate,
        output busy, done, AddressR, AddressS1, AddressS2,
        output S1S2mux, NewDist, BestDist, MotionX, MotionY
    );

    modport slave (
        output start, Accumulate,
        input  busy, done, AddressR, AddressS1, AddressS2,
        input  S1S2mux, NewDist, BestDist, MotionX, MotionY
    );
endinterface

// File: rtl/me_sequencer.sv
// me_sequencer: address/control sequencing and best-match search for the ME PE array.
// Option: define ME_SEQ_EARLY_EXIT_EN to end the search on an accepted zero SAD.
module me_sequencer #(
    parameter int N    = 16,
    parameter int LOGN = $clog2(N)
) (
    input logic      clk,
    input logic      reset,
    me_seq_if.master bus
);
    localparam int KW   = 2 * LOGN + 1;
    localparam int AW   = LOGN + 1;
    localparam int KMAX = N * N + N;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state, state_nxt;
    logic [KW-1:0]     k, k_nxt;
    logic [LOGN-1:0]   dy, dy_nxt;
    logic [AW-1:0]     s1row, s2row;
    logic [2*LOGN-1:0] addr_r;
    logic [2*AW-1:0]   addr_s1, addr_s2;
    logic [N-1:0]      mux_q, nd_q, mux_d, nd_d;
    logic [7:0]        best;
    logic [LOGN-1:0]   mx, my;
    logic [N-1:0][7:0] lanes;
    logic [LOGN-1:0]   lane;
    logic [7:0]        smp;
    logic              smp_vld, take, last_smp, stop_early;

    // Lane i is complete at k = N*N+i+1, so lane = (k mod N) - 1.
    assign lanes    = bus.Accumulate;
    assign lane     = k[LOGN-1:0] - LOGN'(1);
    assign smp      = lanes[lane];
    assign smp_vld  = (state == RUN) && (k > KW'(N * N));
    assign take     = smp_vld && (((dy == '0) && (lane == '0)) || (smp < best));
    assign last_smp = (dy == LOGN'(N - 1)) && (k == KW'(KMAX));

`ifdef ME_SEQ_EARLY_EXIT_EN
    assign stop_early = take && (smp == 8'h00);
`else
    assign stop_early = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        k_nxt     = k;
        dy_nxt    = dy;
        unique case (state)
            IDLE: begin
                k_nxt  = '0;
                dy_nxt = '0;
                if (bus.start) state_nxt = RUN;
            end
            RUN: begin
                if (last_smp || stop_early) begin
                    state_nxt = DONE;
                    k_nxt     = '0;
                    dy_nxt    = '0;
                end else if (k == KW'(KMAX)) begin
                    k_nxt  = '0;
                    dy_nxt = dy + LOGN'(1);
                end else begin
                    k_nxt = k + KW'(1);
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        s1row = k_nxt[KW-1:LOGN] + AW'(dy_nxt);
        s2row = s1row - AW'(1);

        // Controls lag addresses by one cycle: derived from the current k.
        mux_d = '0;
        nd_d  = '0;
        if ((state_nxt == RUN) && (k_nxt != '0)) begin
            for (int i = 0; i < N; i++) begin
                mux_d[i] = k[LOGN-1:0] >= LOGN'(i);
                nd_d[i]  = k == KW'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            k       <= '0;
            dy      <= '0;
            addr_r  <= '0;
            addr_s1 <= '0;
            addr_s2 <= '0;
            mux_q   <= '0;
            nd_q    <= '0;
        end else begin
            state <= state_nxt;
            k     <= k_nxt;
            dy    <= dy_nxt;
            mux_q <= mux_d;
            nd_q  <= nd_d;
            if (state_nxt == RUN) begin
                addr_r  <= k_nxt[2*LOGN-1:0];
                addr_s1 <= {s1row, 1'b0, k_nxt[LOGN-1:0]};
                addr_s2 <= {s2row, 1'b1, k_nxt[LOGN-1:0]};
            end else begin
                addr_r  <= '0;
                addr_s1 <= '0;
                addr_s2 <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            best <= 8'hFF;
            mx   <= '0;
            my   <= '0;
        end else if (take) begin
            best <= smp;
            mx   <= lane;
            my   <= dy;
        end
    end

    assign bus.busy      = (state == RUN);
    assign bus.done      = (state == DONE);
    assign bus.AddressR  = addr_r;
    assign bus.AddressS1 = addr_s1;
    assign bus.AddressS2 = addr_s2;
    assign bus.S1S2mux   = mux_q;
    assign bus.NewDist   = nd_q;
    assign bus.BestDist  = best;
    assign bus.MotionX   = mx;
    assign bus.MotionY   = my;
endmodule
